// File: rtl/dfe_pkg.sv
// -----------------------------------------------------------------------------
// dfe_pkg
// Shared definitions for the DFE sample-capture path.
//   DFE_DATA_WIDTH : default width of the signed DFE core sample.
//   DFE_FLAG_W     : number of per-sample status flags (overflow, underflow).
//   dfe_sample_t   : one captured entry at the default width, laid out as
//                    {data, ovf, udf}. Wider or narrower instances use the
//                    same bit ordering in a flat vector of dfe_entry_width().
// -----------------------------------------------------------------------------
package dfe_pkg;

  localparam int DFE_DATA_WIDTH = 16;
  localparam int DFE_FLAG_W     = 2;

  typedef struct packed {
    logic signed [DFE_DATA_WIDTH-1:0] data;
    logic                             ovf;
    logic                             udf;
  } dfe_sample_t;

  // Bits needed to store one sample plus its flags.
  function automatic int dfe_entry_width(input int data_w);
    return data_w + DFE_FLAG_W;
  endfunction

endpackage

// File: rtl/dfe_sync_fifo.sv
// -----------------------------------------------------------------------------
// dfe_sync_fifo
// Single-clock FIFO holding captured DFE entries. The caller decides when a
// push or pop is legal; this block only stores and sequences entries.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (pointers/level only)
//   i_flush    : drop all contents on the next edge
//   i_push     : write i_wdata at the tail
//   i_pop      : retire the head entry
//   i_wdata    : entry to write
//   o_rdata    : head entry, forced to zero while empty
//   o_level    : occupancy, 0..DEPTH
//   o_full     : o_level == DEPTH
//   o_empty    : o_level == 0
// -----------------------------------------------------------------------------
module dfe_sync_fifo
  import dfe_pkg::*;
#(
  parameter int WIDTH = dfe_entry_width(DFE_DATA_WIDTH),
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("dfe_sync_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  // Pointers are exactly AW bits wide, so +1 wraps DEPTH-1 -> 0 for free.
  // Occupancy is tracked separately because equal pointers mean either
  // empty or full.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop)      r_level <= r_level + 1'b1;
      else if (i_pop && !i_push) r_level <= r_level - 1'b1;
    end
  end

  // Storage carries data only and is never reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_level = r_level;
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  // Masking the head while empty gives a clean zero after reset/flush even
  // though the array itself holds stale or unknown contents.
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/dfe_sample_capture.sv
// -----------------------------------------------------------------------------
// dfe_sample_capture
// Captures DFE core samples and their saturation flags into a FIFO for a
// ready/valid consumer, and keeps drop / saturation statistics.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   valid_in      : sample strobe from the DFE
//   core_in       : signed DFE sample
//   overflow_in   : DFE overflow flag (qualified by valid_in)
//   underflow_in  : DFE underflow flag (qualified by valid_in)
//   flush         : discard FIFO contents (counters untouched)
//   clr_cnt       : zero both statistics counters
//   out_ready     : downstream ready
//   out_valid     : head entry presented (== !empty)
//   out_data      : head sample
//   out_flags     : head flags {overflow, underflow}
//   level         : FIFO occupancy
//   full, empty   : occupancy flags
//   drop_cnt      : samples lost because the FIFO was full (saturating)
//   sat_cnt       : accepted samples carrying a flag (saturating)
// -----------------------------------------------------------------------------
module dfe_sample_capture
  import dfe_pkg::*;
#(
  parameter int DATA_WIDTH = DFE_DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] core_in,
  input  logic                         overflow_in,
  input  logic                         underflow_in,
  input  logic                         flush,
  input  logic                         clr_cnt,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [1:0]                   out_flags,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         full,
  output logic                         empty,
  output logic [CNT_WIDTH-1:0]         drop_cnt,
  output logic [CNT_WIDTH-1:0]         sat_cnt
);

  localparam int ENTRY_W = dfe_entry_width(DATA_WIDTH);

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_sat_hit;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;

  logic [CNT_WIDTH-1:0] r_drop_cnt;
  logic [CNT_WIDTH-1:0] r_sat_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Flush freezes all traffic for its cycle. A pop frees a slot in the same
  // cycle, so a full FIFO still accepts a sample when the head is retiring.
  assign w_pop     = !w_empty && out_ready && !flush;
  assign w_push    = valid_in && (!w_full || w_pop) && !flush;
  assign w_drop    = valid_in && w_full && !w_pop && !flush;
  assign w_sat_hit = w_push && (overflow_in || underflow_in);

  // Entry layout matches dfe_sample_t: {data, ovf, udf}.
  assign w_wdata = {core_in, overflow_in, underflow_in};

  dfe_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_level (level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Clear wins over any increment landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_drop_cnt <= '0;
      r_sat_cnt  <= '0;
    end else begin
      if (w_drop)    r_drop_cnt <= sat_inc(r_drop_cnt);
      if (w_sat_hit) r_sat_cnt  <= sat_inc(r_sat_cnt);
    end
  end

  assign full      = w_full;
  assign empty     = w_empty;
  assign out_valid = !w_empty;
  assign out_data  = w_rdata[ENTRY_W-1:DFE_FLAG_W];
  assign out_flags = w_rdata[DFE_FLAG_W-1:0];
  assign drop_cnt  = r_drop_cnt;
  assign sat_cnt   = r_sat_cnt;

endmodule

// File: doc/dfe_sample_capture.md
DFE_SAMPLE_CAPTURE -- requirements
Module: dfe_sample_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the width of the signed sample from the DFE core output.
REQ-002 SHALL have parameter DEPTH, default 16, the FIFO depth in samples; it SHALL be a power of 2 and at least 2.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, the width of the statistics counters.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports SHALL be, in this order:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  sample strobe from the DFE valid_out.
- core_in  in  DATA_WIDTH signed  sample from the DFE core_out.
- overflow_in  in  1  DFE overflow flag, qualified by valid_in.
- underflow_in  in  1  DFE underflow flag, qualified by valid_in.
- flush  in  1  discards all FIFO contents.
- clr_cnt  in  1  clears the statistics counters.
- out_ready  in  1  downstream ready.
- out_valid  out  1  the head entry is presented.
- out_data  out  DATA_WIDTH signed  head sample.
- out_flags  out  2  head flags {overflow, underflow}.
- level  out  $clog2(DEPTH)+1  occupancy.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- drop_cnt  out  CNT_WIDTH  count of samples lost because the FIFO was full.
- sat_cnt  out  CNT_WIDTH  count of accepted samples flagged overflow or underflow.

Function
REQ-006 A push SHALL occur when valid_in=1 AND (full=0 OR pop occurs in the same cycle) AND flush=0.
REQ-007 A pop SHALL occur when out_valid=1 AND out_ready=1 AND flush=0.
REQ-008 Each entry SHALL store {core_in, overflow_in, underflow_in} unmodified: no truncation, no sign change.
REQ-009 Latency SHALL be one cycle from a push into an empty FIFO to out_valid=1; there is no combinational bypass from valid_in to out_valid.
REQ-010 out_valid SHALL equal !empty.
REQ-011 While out_valid=1 and out_ready=0, out_data and out_flags SHALL hold stable.
REQ-012 A push and a pop in the same cycle SHALL leave level unchanged; this applies at full (pass-through) and at all other levels.
REQ-013 A pop with no push SHALL decrement level.
REQ-014 Pop at empty is impossible, since out_valid=0.
REQ-015 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0; full and empty SHALL be derived from level, never from pointer equality alone.
REQ-016 valid_in=1 with full=1 and no pop SHALL discard the sample, leave the FIFO unchanged, and increment drop_cnt.
REQ-017 sat_cnt SHALL increment by 1 per pushed sample with overflow_in OR underflow_in.
REQ-018 Dropped samples SHALL NOT count toward sat_cnt.
REQ-019 drop_cnt and sat_cnt SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-020 flush=1 SHALL, on the next edge, set both pointers and level to 0.
REQ-021 When flush=1, no push, pop or drop SHALL occur that cycle; a coincident valid_in sample is discarded and not counted.
REQ-022 flush SHALL leave the counters unchanged.
REQ-023 clr_cnt=1 SHALL zero both counters on the next edge; clr_cnt SHALL take priority over a same-cycle increment.
REQ-024 clr_cnt SHALL leave FIFO contents unchanged.

Reset
REQ-025 rst=1 SHALL, on the next edge, set pointers, level, drop_cnt and sat_cnt to 0.
REQ-026 Reset values of the outputs SHALL be: out_valid=0, empty=1, full=0, level=0, drop_cnt=0, sat_cnt=0, out_flags=0, out_data=0.
REQ-027 Storage array contents need not be reset.
REQ-028 rst SHALL override flush, clr_cnt, valid_in and out_ready.
REQ-029 A reset asserted mid-stream SHALL lose all queued samples; out_valid SHALL be 0 in the cycle after the reset edge.

Structure
REQ-030 Shared package dfe_pkg SHALL hold the DATA_WIDTH default and a packed typedef dfe_sample_t {data, ovf, udf}.
REQ-031 Storage and pointer logic SHALL reside in one sub-module, dfe_sync_fifo (parameterised width and depth).
REQ-032 The counters and push/drop qualification SHALL reside in dfe_sample_capture.

Verification
REQ-033 Reset, then push 5 samples (0x0001..0x0005) with out_ready=0 -> level=5, out_data=0x0001 stable; then set out_ready=1 -> samples pop in order 1..5, and empty=1 after the fifth pop.
REQ-034 Push 18 samples with out_ready=0 (DEPTH=16) -> full=1, drop_cnt=2, and samples 17-18 are absent from the pop sequence.
REQ-035 At full, assert valid_in=1 and out_ready=1 together for 4 cycles -> level stays 16, drop_cnt unchanged, and the FIFO order is preserved.
REQ-036 Push 3 samples flagged overflow, 2 flagged underflow and 1 clean (0x8000) -> sat_cnt=5, and out_flags pops as 10,10,10,01,01,00 with out_data=0x8000 intact.
REQ-037 With level=7, assert flush and valid_in in the same cycle -> next cycle level=0 and empty=1, with drop_cnt and sat_cnt unchanged; assert clr_cnt -> both counters read 0.
REQ-038 Preload drop_cnt to 0xFFFF (CNT_WIDTH=16) via sustained overflow of the full FIFO, then add 3 more drops -> drop_cnt stays 0xFFFF; assert rst mid-stream -> all outputs return to their reset values.
